// File: rtl/tx_enable_sequencer_pkg.sv
// Shared definitions for the TX enable sequencer: state codes, stage bit
// positions and default timing parameters.
package tx_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StRampUp    = 3'd1,
    StWaitValid = 3'd2,
    StRun       = 3'd3,
    StDrain     = 3'd4,
    StRampDown  = 3'd5,
    StError     = 3'd6
  } state_e;

  localparam int unsigned FRAME_GEN    = 0;
  localparam int unsigned ENCODER      = 1;
  localparam int unsigned CLOCK_COMP   = 2;
  localparam int unsigned SCRAMBLER    = 3;
  localparam int unsigned PC_1_20      = 4;
  localparam int unsigned AM_INSERTION = 5;

  localparam int unsigned DEFAULT_STEP_WAIT     = 4;
  localparam int unsigned DEFAULT_DRAIN_WAIT    = 64;
  localparam int unsigned DEFAULT_VALID_TIMEOUT = 1024;

  function automatic logic is_busy(input state_e s);
    return s inside {StRampUp, StWaitValid, StDrain, StRampDown};
  endfunction

endpackage

// File: rtl/tx_enable_sequencer_if.sv
// Control/status bundle between the TX register block and the enable sequencer.
interface tx_enable_sequencer_if #(
  parameter int unsigned N_STAGES = 6
);
  logic                i_start;
  logic                i_stop;
  logic                i_clear_error;
  logic                i_valid;
  logic [N_STAGES-1:0] i_rf_enb;
  logic [N_STAGES-1:0] o_enb;
  logic                o_running;
  logic                o_busy;
  logic                o_error;
  logic [2:0]          o_state;

  modport slave (
    input  i_start, i_stop, i_clear_error, i_valid, i_rf_enb,
    output o_enb, o_running, o_busy, o_error, o_state
  );

  modport master (
    output i_start, i_stop, i_clear_error, i_valid, i_rf_enb,
    input  o_enb, o_running, o_busy, o_error, o_state
  );
endinterface

// File: rtl/tx_enable_sequencer_seq_timer.sv
// Loadable saturating up-counter; done is high while the count has reached
// the target supplied by the current phase.
module seq_timer #(
  parameter int unsigned NB_TIMER = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                load_i,
  input  logic [NB_TIMER-1:0] load_val_i,
  input  logic                inc_i,
  input  logic [NB_TIMER-1:0] target_i,
  output logic                done_o
);

  logic [NB_TIMER-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + NB_TIMER'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q >= target_i);

endmodule

// File: rtl/tx_enable_sequencer.sv
// Brings TX datapath stage enables up sink-first and down source-first, and
// supervises the final-stage valid with a sticky timeout error.
module tx_enable_sequencer
  import tx_ctrl_pkg::*;
#(
  parameter int unsigned N_STAGES      = 6,
  parameter int unsigned NB_TIMER      = 16,
  parameter int unsigned STEP_WAIT     = DEFAULT_STEP_WAIT,
  parameter int unsigned DRAIN_WAIT    = DEFAULT_DRAIN_WAIT,
  parameter int unsigned VALID_TIMEOUT = DEFAULT_VALID_TIMEOUT
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  tx_enable_sequencer_if.slave  bus
);

  localparam logic [NB_TIMER-1:0] StepCnt    = NB_TIMER'(STEP_WAIT);
  localparam logic [NB_TIMER-1:0] DrainCnt   = NB_TIMER'(DRAIN_WAIT);
  localparam logic [NB_TIMER-1:0] TimeoutCnt = NB_TIMER'(VALID_TIMEOUT);
  localparam logic [NB_TIMER-1:0] TmrOne     = NB_TIMER'(1);
  localparam logic [N_STAGES-1:0] EnbLsb     = N_STAGES'(1);

  state_e              state_q, state_d;
  logic [N_STAGES-1:0] seq_q, seq_d;
  logic [N_STAGES-1:0] enb_q;
  logic                running_q, busy_q, error_q;

  logic                tmr_load, tmr_inc, tmr_done;
  logic [NB_TIMER-1:0] tmr_val, tmr_target;

  seq_timer #(
    .NB_TIMER(NB_TIMER)
  ) u_seq_timer (
    .clk_i     (i_clock),
    .rst_ni    (i_reset),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .inc_i     (tmr_inc),
    .target_i  (tmr_target),
    .done_o    (tmr_done)
  );

  always_comb begin
    state_d    = state_q;
    seq_d      = seq_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    tmr_inc    = 1'b0;
    tmr_target = '0;

    case (state_q)
      StIdle: begin
        if (bus.i_start && !bus.i_stop) begin
          state_d             = StRampUp;
          seq_d               = '0;
          seq_d[AM_INSERTION] = 1'b1;
          tmr_load            = 1'b1;
          tmr_val             = TmrOne;
        end
      end

      StRampUp: begin
        tmr_target = StepCnt;
        tmr_load   = 1'b1;
        tmr_val    = TmrOne;
        if (bus.i_stop) begin
          // Frame generator is not on yet, so unwind without a drain phase.
          seq_d   = seq_q & (seq_q - EnbLsb);
          state_d = (seq_d == '0) ? StIdle : StRampDown;
        end else if (tmr_done) begin
          seq_d = seq_q | (seq_q >> 1);
          if (seq_d[FRAME_GEN]) begin
            state_d = StWaitValid;
            tmr_val = '0;
          end
        end else begin
          tmr_load = 1'b0;
          tmr_inc  = 1'b1;
        end
      end

      StWaitValid, StRun: begin
        tmr_target = TimeoutCnt;
        if (bus.i_stop) begin
          state_d          = StDrain;
          seq_d[FRAME_GEN] = 1'b0;
          tmr_load         = 1'b1;
          tmr_val          = TmrOne;
        end else if (tmr_done) begin
          state_d = StError;
          seq_d   = '0;
        end else if (bus.i_valid) begin
          state_d  = StRun;
          tmr_load = 1'b1;
        end else begin
          tmr_inc = 1'b1;
        end
      end

      StDrain: begin
        tmr_target = DrainCnt;
        if (tmr_done) begin
          seq_d    = seq_q & (seq_q - EnbLsb);
          state_d  = (seq_d == '0) ? StIdle : StRampDown;
          tmr_load = 1'b1;
          tmr_val  = TmrOne;
        end else begin
          tmr_inc = 1'b1;
        end
      end

      StRampDown: begin
        tmr_target = StepCnt;
        if (tmr_done) begin
          seq_d    = seq_q & (seq_q - EnbLsb);
          state_d  = (seq_d == '0) ? StIdle : StRampDown;
          tmr_load = 1'b1;
          tmr_val  = TmrOne;
        end else begin
          tmr_inc = 1'b1;
        end
      end

      StError: begin
        seq_d = '0;
        if (bus.i_clear_error) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        seq_d   = '0;
      end
    endcase
  end

  // Status flags are decoded from the next state so every output is a flop.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= StIdle;
      seq_q     <= '0;
      enb_q     <= '0;
      running_q <= 1'b0;
      busy_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      seq_q     <= seq_d;
      enb_q     <= seq_d & bus.i_rf_enb;
      running_q <= (state_d == StRun);
      busy_q    <= is_busy(state_d);
      error_q   <= (state_d == StError);
    end
  end

  assign bus.o_enb     = enb_q;
  assign bus.o_running = running_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_error   = error_q;
  assign bus.o_state   = state_q;

endmodule
